// File: rtl/mem_loader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_loader_pkg : shared types and address helper for mem_loader    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [31:0] WORD_BYTES = 32'd4;

  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] idx);
    return base + idx * WORD_BYTES;
  endfunction

endpackage
`default_nettype wire

// File: rtl/loader_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | loader_counter : word index counter with terminal flag             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module loader_counter #(
  parameter int CNT_W = 7
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] len_i,
  output logic [CNT_W-1:0] idx_o,
  output logic             term_o
);

  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (inc_i) begin
      idx_d = idx_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o  = idx_q;
  // Only meaningful when len_i is non-zero; a zero length never enters a phase.
  assign term_o = (idx_q == (len_i - CNT_W'(1)));

endmodule
`default_nettype wire

// File: rtl/mem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_loader : streams words into memory, then reads back and sums   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int CNT_W       = $clog2(DEPTH_WORDS) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [31:0]      base_addr_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             s_valid_i,
  input  logic [31:0]      s_data_i,
  output logic             s_ready_o,
  output logic             we_o,
  output logic [31:0]      a_o,
  output logic [31:0]      wd_o,
  input  logic [31:0]      rd_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [31:0]      checksum_o,
  output logic             verify_err_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DEPTH_WORDS);

  state_t           state_q, state_d;
  logic [31:0]      base_q, base_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      checksum_q, checksum_d;
  logic [31:0]      rsum_q, rsum_d;
  logic             verr_q, verr_d;

  logic [CNT_W-1:0] count_sat;
  logic [CNT_W-1:0] idx;
  logic             idx_term;
  logic             ctr_clr;
  logic             ctr_inc;
  logic [31:0]      rsum_final;

  assign count_sat  = (count_i > MAX_CNT) ? MAX_CNT : count_i;
  assign rsum_final = rsum_q + rd_i;

  loader_counter #(
    .CNT_W (CNT_W)
  ) u_idx (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (ctr_clr),
    .inc_i  (ctr_inc),
    .len_i  (cnt_q),
    .idx_o  (idx),
    .term_o (idx_term)
  );

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    checksum_d = checksum_q;
    rsum_d     = rsum_q;
    verr_d     = verr_q;
    ctr_clr    = 1'b0;
    ctr_inc    = 1'b0;
    s_ready_o  = 1'b0;
    we_o       = 1'b0;
    a_o        = '0;
    wd_o       = '0;
    done_o     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d     = base_addr_i & ~32'h3;
          cnt_d      = count_sat;
          checksum_d = '0;
          rsum_d     = '0;
          verr_d     = 1'b0;
          ctr_clr    = 1'b1;
          state_d    = (count_sat == '0) ? DONE : WRITE;
        end
      end

      // Write strobes are combinational so memory captures on the handshake edge.
      WRITE: begin
        s_ready_o = 1'b1;
        we_o      = s_valid_i;
        a_o       = word_addr(base_q, 32'(idx));
        wd_o      = s_data_i;
        if (s_valid_i) begin
          checksum_d = checksum_q + s_data_i;
          if (idx_term) begin
            ctr_clr = 1'b1;
            state_d = VERIFY;
          end else begin
            ctr_inc = 1'b1;
          end
        end
      end

      VERIFY: begin
        a_o    = word_addr(base_q, 32'(idx));
        rsum_d = rsum_final;
        if (idx_term) begin
          ctr_clr = 1'b1;
          verr_d  = (rsum_final != checksum_q);
          state_d = DONE;
        end else begin
          ctr_inc = 1'b1;
        end
      end

      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      base_q     <= '0;
      cnt_q      <= '0;
      checksum_q <= '0;
      rsum_q     <= '0;
      verr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      checksum_q <= checksum_d;
      rsum_q     <= rsum_d;
      verr_q     <= verr_d;
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign checksum_o   = checksum_q;
  assign verify_err_o = verr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_loader : randomized self-checking bench for mem_loader      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_mem_loader;

  localparam int DEPTH = 64;
  localparam int CW    = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [31:0]   base_addr;
  logic [CW-1:0] count;
  logic          s_valid;
  logic [31:0]   s_data;
  logic          s_ready;
  logic          we;
  logic [31:0]   a;
  logic [31:0]   wd;
  logic [31:0]   rd;
  logic          busy;
  logic          done;
  logic [31:0]   checksum;
  logic          verify_err;

  logic [31:0]   mem [0:255];
  bit            corrupt_on;
  logic [31:0]   corrupt_addr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Responder: combinational read, optionally flipping bit 0 of one word.
  assign rd = mem[a[9:2]] ^ {31'd0, (corrupt_on && (a == corrupt_addr))};

  mem_loader #(
    .DEPTH_WORDS (DEPTH),
    .CNT_W       (CW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .count_i      (count),
    .s_valid_i    (s_valid),
    .s_data_i     (s_data),
    .s_ready_o    (s_ready),
    .we_o         (we),
    .a_o          (a),
    .wd_o         (wd),
    .rd_i         (rd),
    .busy_o       (busy),
    .done_o       (done),
    .checksum_o   (checksum),
    .verify_err_o (verify_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // mode: 0 = valid always high, 1 = valid on alternate cycles, 2 = random valid
  task automatic run_xfer(input logic [31:0] base_raw, input int cnt, input int mode,
                          input bit seq_data, input int bad_idx);
    logic [31:0] base;
    logic [31:0] sum;
    logic [31:0] wa;
    logic [31:0] stream [$];
    int          n, ptr, vk, last_hs, dc, exp_dc;
    bit          seen, exp_err;

    base = base_raw & 32'hFFFF_FFFC;
    n    = (cnt > DEPTH) ? DEPTH : cnt;
    sum  = '0;
    for (int k = 0; k < n; k++) begin
      stream.push_back(seq_data ? 32'(k + 1) : $urandom);
      sum += stream[k];
    end
    exp_err      = (bad_idx >= 0) && (bad_idx < n);
    corrupt_on   = (bad_idx >= 0);
    corrupt_addr = base + 32'(4 * bad_idx);

    @(negedge clk);
    start     = 1'b1;
    base_addr = base_raw;
    count     = CW'(cnt);
    s_valid   = 1'b0;
    #1 check_eq("idle_busy", 32'(busy), 32'd0);

    ptr = 0; vk = 0; last_hs = 0; dc = 0; seen = 1'b0;
    for (int c = 1; c <= 400 && !seen; c++) begin
      @(negedge clk);
      start   = 1'b0;
      s_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 1) : 1'($urandom_range(0, 1));
      s_data  = (ptr < n) ? stream[ptr] : $urandom;
      #1;
      if (c == 1) check_eq("verr_cleared", 32'(verify_err), 32'd0);
      if (done) begin
        seen = 1'b1;
        dc   = c;
      end else if (ptr < n) begin
        check_eq("s_ready", 32'(s_ready), 32'd1);
        check_eq("we_vs_valid", 32'(we), 32'(s_valid));
        if (s_valid) begin
          wa = base + 32'(4 * ptr);
          check_eq("w_addr", a, wa);
          check_eq("w_data", wd, stream[ptr]);
          mem[wa[9:2]] = stream[ptr];
          ptr++;
          last_hs = c;
        end
      end else if (busy) begin
        check_eq("we_verify", 32'(we), 32'd0);
        check_eq("v_addr", a, base + 32'(4 * vk));
        vk++;
      end
    end

    if (!seen) begin
      check_eq("done_timeout", 32'd0, 32'd1);
    end else begin
      exp_dc = (n == 0) ? 1 : last_hs + n + 1;
      check_eq("done_cycle", 32'(dc), 32'(exp_dc));
      check_eq("n_writes", 32'(ptr), 32'(n));
      check_eq("n_verify", 32'(vk), 32'(n));
      check_eq("checksum", checksum, sum);
      check_eq("verify_err", 32'(verify_err), 32'(exp_err));
    end

    @(negedge clk);
    s_valid = 1'b0;
    #1;
    check_eq("done_pulse", 32'(done), 32'd0);
    check_eq("busy_after", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check_eq("csum_hold", checksum, sum);
    check_eq("verr_hold", 32'(verify_err), 32'(exp_err));
  endtask

  task automatic reset_mid();
    bit saw_done;
    saw_done = 1'b0;
    @(negedge clk);
    start     = 1'b1;
    base_addr = 32'h40;
    count     = CW'(4);
    s_valid   = 1'b1;
    s_data    = $urandom;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      start  = 1'b0;
      s_data = $urandom;
    end
    @(negedge clk);
    #2;
    check_eq("rst_pre_we", 32'(we), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_we", 32'(we), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (done) saw_done = 1'b1;
      if (c == 1) rst_n = 1'b1;
    end
    s_valid = 1'b0;
    check_eq("rst_no_done", 32'(saw_done), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    count      = '0;
    s_valid    = 1'b0;
    s_data     = '0;
    corrupt_on = 1'b0;
    corrupt_addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;

    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_s_ready", 32'(s_ready), 32'd0);
    check_eq("rst_we0", 32'(we), 32'd0);
    check_eq("rst_a", a, 32'd0);
    check_eq("rst_wd", wd, 32'd0);
    check_eq("rst_busy0", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_csum", checksum, 32'd0);
    check_eq("rst_verr", 32'(verify_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_xfer(32'h10, 4, 0, 1'b1, -1);
    run_xfer(32'h10, 4, 1, 1'b1, -1);
    run_xfer(32'h20, 0, 0, 1'b1, -1);
    run_xfer(32'h103, DEPTH + 5, 0, 1'b0, -1);
    run_xfer(32'h80, 4, 0, 1'b0, 2);
    run_xfer(32'h80, 4, 0, 1'b0, -1);
    reset_mid();
    run_xfer(32'h40, 4, 0, 1'b1, -1);

    for (int t = 0; t < 10; t++) begin
      run_xfer(32'($urandom_range(0, 32'h2FF)), int'($urandom_range(0, 80)),
               int'($urandom_range(0, 2)), 1'b0,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Initiator for the data-memory port: drives we / a / wd and samples rd, the same word-addressed interface the data memory responds on.
- Accepts a stream of 32-bit words over a valid/ready handshake and writes them to consecutive word addresses starting at base_addr.
- Then reads the region back and compares the modular sum of written data against read data.
- Used to preload data/program images and to self-check the memory path before releasing the processor.

Parameters:
- DEPTH_WORDS, 64, words addressable in the target memory; maximum transfer length.
- CNT_W, $clog2(DEPTH_WORDS)+1, width of the count input and internal word index.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin a transfer; sampled only in IDLE.
- base_addr  input  32  byte address of the first word; bits [1:0] ignored (forced to 0).
- count  input  CNT_W  number of words; values above DEPTH_WORDS saturate to DEPTH_WORDS.
- s_valid  input  1  stream word available.
- s_data  input  32  stream word.
- s_ready  output  1  loader accepts s_data this cycle.
- we  output  1  memory write enable.
- a  output  32  memory byte address.
- wd  output  32  memory write data.
- rd  input  32  memory read data; combinational from a.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at completion.
- checksum  output  32  modular sum of written words; valid from done onward.
- verify_err  output  1  sticky until the next start; set when readback sum differs from checksum.

Behaviour:
- States: IDLE, WRITE, VERIFY, DONE.
- Reset (async, immediate): state=IDLE; s_ready=0, we=0, a=0, wd=0, busy=0, done=0, checksum=0, verify_err=0; word index=0.
- IDLE, start=1: latch base_addr & ~3 and saturated count; clear checksum, readback sum and verify_err.
  - Latched count=0: go to DONE.
  - Otherwise: go to WRITE.
  - start in any other state is ignored.
- WRITE:
  - s_ready=1 combinationally.
  - we = s_valid; a = base + 4*idx; wd = s_data. Outputs are combinational so memory captures on the same edge as the handshake.
  - On handshake: checksum += s_data (mod 2^32); idx++.
  - Last word accepted: idx resets to 0; go to VERIFY.
  - s_valid=0: we=0, nothing advances, no timeout.
- VERIFY:
  - we=0; s_ready=0; a = base + 4*idx.
  - Each cycle: readback sum += rd; idx++.
  - After count cycles, go to DONE.
  - On entry to DONE: verify_err = (readback sum with final rd) != checksum.
- DONE: done=1 for exactly one cycle; go to IDLE. busy is low in the following cycle.
- Address arithmetic is 32-bit and wraps modulo 2^32. No bounds check against DEPTH_WORDS beyond count saturation.
- Latency for a transfer of N≥1 words with s_valid held high:
  - start to first we: 1 cycle.
  - N write cycles, then N verify cycles, then done: done asserts 2N+1 cycles after the start cycle.
- Reset mid-operation: we drops asynchronously; a partial write region is left as-is; no done pulse.
- checksum and verify_err hold their values in IDLE until the next accepted start.

Decomposition:
- Package mem_loader_pkg:
  - state_t enum {IDLE, WRITE, VERIFY, DONE}.
  - WORD_BYTES=4.
  - Function word_addr(base, idx) returning base + idx*WORD_BYTES.
- One sub-module, loader_counter:
  - Loadable index counter with terminal flag (idx == count-1) and synchronous clear.
  - Reused for the WRITE and VERIFY phases.

Test Plan:
- count=4, base=0x10, stream 1,2,3,4 with s_valid always high:
  - we high 4 cycles at a=0x10,0x14,0x18,0x1C.
  - checksum=10; verify_err=0; done 9 cycles after start.
- Same transfer with s_valid low on alternate cycles:
  - we asserted only on handshake cycles; addresses remain contiguous; checksum=10.
- count=0:
  - done 1 cycle after start; we never asserted; checksum=0.
- count=DEPTH_WORDS+5 (69):
  - exactly 64 writes; final address base+0xFC.
- Responder model that corrupts the read of word 2 by XOR 0x1:
  - verify_err=1 at done; remains 1 until the next start.
- Reset deasserted-to-asserted during WRITE after 2 words:
  - we=0 and busy=0 immediately; no done pulse; a new start afterwards completes normally.
